// File: rtl/interval_timer.sv
// interval_timer: memory-mapped countdown timer responder for the processor bus.
// Registers: 0 LOAD (R/W), 1 COUNT (RO), 2 CTRL (bit 0 EN), 3 STATUS (bit 0 Done, write clears).
// Read data is registered (one-cycle latency).
// Optional feature: define TIMER_AUTORELOAD_EN for a periodic timer that reloads COUNT from
// LOAD on expiry; otherwise the timer stops in EXPIRED and waits for a CTRL write.
module interval_timer #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic [1:0]  a_i,
  input  logic        w_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o,
  output logic        done_o
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

  state_e          state_q, state_d;
  logic [15:0]     load_q, load_d;
  logic [15:0]     count_q, count_d;
  logic [PsW-1:0]  presc_q, presc_d;
  logic            en_q, en_d;
  logic            done_q, done_d;
  logic [15:0]     q_q, q_d;

  logic wr, rd, tick;

  // Next-state: status clear is applied before the expiry set so a same-edge expiry wins,
  // and a CTRL write is applied last so it overrides the run/expiry update.
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;
    en_d    = en_q;
    done_d  = done_q;
    q_d     = q_q;

    wr   = cs_i & w_i;
    rd   = cs_i & ~w_i;
    tick = (state_q == StRun) && (presc_q == PsMax);

    if (rd) begin
      unique case (a_i)
        2'd0:    q_d = load_q;
        2'd1:    q_d = count_q;
        2'd2:    q_d = {15'b0, en_q};
        default: q_d = {15'b0, done_q};
      endcase
    end

    if (wr && (a_i == 2'd0)) load_d = d_i;
    if (wr && (a_i == 2'd3)) done_d = 1'b0;

    if (state_q == StRun) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (count_q <= 16'd1) begin
          done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
          count_d = load_q;
`else
          count_d = 16'd0;
          en_d    = 1'b0;
          state_d = StExpired;
`endif
        end else begin
          count_d = count_q - 16'd1;
        end
      end
    end

    if (wr && (a_i == 2'd2)) begin
      if (d_i[0]) begin
        count_d = load_q;
        presc_d = '0;
        en_d    = 1'b1;
        state_d = StRun;
      end else begin
        // Stop freezes COUNT at its current value, even over a coincident tick.
        count_d = count_q;
        presc_d = presc_q;
        en_d    = 1'b0;
        state_d = StIdle;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      done_q  <= done_d;
      q_q     <= q_d;
    end
  end

  assign q_o    = q_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer (PRESCALE=4): directed scenarios plus random bus traffic,
// checked by a scoreboard against an arithmetic timeline model of the timer.
module tb_interval_timer;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs  = 1'b0;
  logic        w   = 1'b0;
  logic [1:0]  a   = 2'd0;
  logic [15:0] d   = 16'd0;
  logic [15:0] q;
  logic        done;

  always #5 clk = ~clk;

  interval_timer #(.PRESCALE(P)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cs_i   (cs),
    .a_i    (a),
    .w_i    (w),
    .d_i    (d),
    .q_o    (q),
    .done_o (done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  // Model: a running timer is described by the edge it (re)started at and its start value.
  logic [15:0] m_load = 16'd0;
  logic [15:0] m_n = 16'd0;
  logic [15:0] m_frozen = 16'd0;
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  int          m_seg = 0;

  function automatic void check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  // COUNT value holding after edge e.
  function automatic logic [15:0] count_at(int e);
    if (m_run) return m_n - 16'((e - m_seg) / P);
    return m_frozen;
  endfunction

  task automatic model_edge(logic r, logic c, logic ww, logic [1:0] aa, logic [15:0] dd);
    int e;
    logic [15:0] pre_cnt;
    bit expire;
    e = cyc;
    if (r) begin
      m_load = 0; m_n = 0; m_frozen = 0; m_run = 0; m_done = 0; m_seg = e;
      return;
    end
    pre_cnt = count_at(e - 1);
    if (c && !ww) begin
      case (aa)
        2'd0:    exp_q.push_back(m_load);
        2'd1:    exp_q.push_back(pre_cnt);
        2'd2:    exp_q.push_back({15'b0, m_run});
        default: exp_q.push_back({15'b0, m_done});
      endcase
    end
    expire = m_run && (e == m_seg + ((m_n == 0) ? 1 : int'(m_n)) * int'(P));
    if (c && ww && aa == 2'd3) m_done = 1'b0;
    if (expire) begin
      m_done = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
      m_seg = e;
      m_n   = m_load;
`else
      m_run    = 1'b0;
      m_frozen = 16'd0;
`endif
    end
    if (c && ww && aa == 2'd2) begin
      if (dd[0]) begin
        m_run = 1'b1; m_seg = e; m_n = m_load;
      end else begin
        m_run = 1'b0; m_frozen = pre_cnt;
      end
    end
    if (c && ww && aa == 2'd0) m_load = dd;
  endtask

  task automatic step(logic r, logic c, logic ww, logic [1:0] aa, logic [15:0] dd);
    rst = r; cs = c; w = ww; a = aa; d = dd;
    @(posedge clk);
    cyc++;
    model_edge(r, c, ww, aa, dd);
    #1;
    rst = 1'b0; cs = 1'b0; w = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
  endtask

  task automatic wr(logic [1:0] aa, logic [15:0] dd);
    step(1'b0, 1'b1, 1'b1, aa, dd);
  endtask

  task automatic rd(logic [1:0] aa);
    step(1'b0, 1'b1, 1'b0, aa, 16'd0);
  endtask

  // Monitor: pops the scoreboard on each read, otherwise Q must hold; Done checked every cycle.
  initial begin
    bit fire, rs;
    logic [15:0] last_q, e;
    last_q = 16'd0;
    forever begin
      @(posedge clk);
      fire = cs & ~w & ~rst;
      rs   = rst;
      @(negedge clk);
      if (rs) last_q = 16'd0;
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL read_queue at cycle %0d: got read with no expected entry", cyc);
        end else begin
          e = exp_q.pop_front();
          check("read_q", q, e);
          last_q = e;
        end
      end else begin
        check("q_hold", q, last_q);
      end
      check("done", {15'b0, done}, {15'b0, m_done});
    end
  end

  initial begin
    int r;
    // Reset state and register readback.
    step(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    for (int i = 0; i < 4; i++) rd(2'(i));
    idle(1);

    // Basic run: LOAD=3, start, COUNT at k+5, expiry at k+12.
    wr(2'd0, 16'd3);
    wr(2'd2, 16'd1);
    idle(4);
    rd(2'd1);
    idle(6);
    rd(2'd1); rd(2'd2); rd(2'd3);
    idle(3);
    wr(2'd3, 16'h1234);
    idle(14);
    wr(2'd3, 16'd0);

    // STATUS write on the expiry edge, then one cycle later.
    wr(2'd2, 16'd1);
    idle(11);
    wr(2'd3, 16'd0);
    wr(2'd3, 16'd0);
    wr(2'd2, 16'd0);
    rd(2'd1);

    // Reset at k+6 of a run, then quiet.
    wr(2'd2, 16'd1);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    idle(20);
    rd(2'd1); rd(2'd2); rd(2'd0);

    // Stop mid-run freezes COUNT; writes to COUNT ignored; cs=0 ignored; LOAD=0.
    wr(2'd0, 16'd5);
    wr(2'd2, 16'd1);
    idle(9);
    wr(2'd2, 16'd0);
    wr(2'd1, 16'hbeef);
    idle(8);
    rd(2'd1);
    step(1'b0, 1'b0, 1'b1, 2'd0, 16'h7777);
    step(1'b0, 1'b0, 1'b0, 2'd2, 16'd0);
    rd(2'd0);
    wr(2'd0, 16'd0);
    wr(2'd2, 16'd1);
    idle(9);
    rd(2'd1); rd(2'd3);
    wr(2'd2, 16'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       step(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      else if (r < 38) rd(2'($urandom_range(0, 3)));
      else if (r < 45) wr(2'd0, 16'($urandom_range(0, 4)));
      else if (r < 51) wr(2'd2, {15'($urandom), ($urandom_range(0, 9) < 7)});
      else if (r < 55) wr(2'd3, 16'($urandom));
      else if (r < 57) wr(2'd1, 16'($urandom));
      else if (r < 61) step(1'b0, 1'b0, 1'($urandom), 2'($urandom), 16'($urandom));
      else             idle(1);
    end
    idle(2);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
